// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment decode constants and defaults
package seg7_pkg;

    localparam int DEF_REFRESH_DIV  = 100000;
    localparam int DEF_BLINK_FRAMES = 250;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment order a..g from MSB to LSB, active low.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// rtl/seg7_prescaler.sv - free-running divider producing one tick every DIV cycles
module seg7_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - time-multiplexed N-digit seven-segment driver
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic [6:0]              CA,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_start
);

    localparam int N  = NUM_DIGITS;
    localparam int BW = 7 * N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    logic          tick;
    logic          frame_wrap;
    logic [IW-1:0] idx_q;
    logic [FW-1:0] fcnt_q;
    logic          phase_q;
    logic [BW-1:0] in_buf;
    logic [BW-1:0] pend_q;
    logic [BW-1:0] disp_q;
    logic [N-1:0]  an_q;
    logic [N-1:0]  an_d;
    logic [6:0]    ca_q;
    logic [6:0]    ca_d;
    logic          dp_q;
    logic          dp_d;
    logic          fs_q;

    logic [4*N-1:0] disp_val;
    logic [N-1:0]   disp_dp;
    logic [N-1:0]   disp_blank;
    logic [N-1:0]   disp_blink;
    logic [N-1:0]   lz;
    logic           upper_zero;
    logic           dark;

    seg7_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign frame_wrap = tick && (idx_q == IDX_LAST);
    assign in_buf     = {value_in, dp_in, blank_in, blink_in};
    assign disp_val   = disp_q[BW-1 -: 4*N];
    assign disp_dp    = disp_q[3*N-1 -: N];
    assign disp_blank = disp_q[2*N-1 -: N];
    assign disp_blink = disp_q[N-1:0];

    // A digit is leading-zero suppressed when it and every digit above it is 0.
    always_comb begin
        upper_zero = 1'b1;
        lz         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_val[4*k +: 4] == 4'h0);
            lz[k]      = upper_zero && (k != 0) && (LZ_BLANK != 0);
        end
    end

    always_comb begin
        an_d = '1;
        ca_d = SEG_BLANK;
        dp_d = 1'b1;
        dark = !en || disp_blank[idx_q] || (disp_blink[idx_q] && phase_q)
               || (lz[idx_q] && !disp_dp[idx_q]);
        if (!dark) begin
            an_d[idx_q] = 1'b0;
            dp_d        = ~disp_dp[idx_q];
            // A suppressed digit with its point set keeps only the point lit.
            if (!lz[idx_q]) begin
                ca_d = seg7_decode(disp_val[{idx_q, 2'b00} +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            pend_q  <= '0;
            disp_q  <= '0;
            an_q    <= '1;
            ca_q    <= SEG_BLANK;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            if (tick) begin
                idx_q <= frame_wrap ? '0 : idx_q + 1'b1;
            end
            if (load) begin
                pend_q <= in_buf;
            end
            if (frame_wrap) begin
                disp_q <= load ? in_buf : pend_q;
                fcnt_q <= (fcnt_q == FRM_LAST) ? '0 : fcnt_q + 1'b1;
                if (fcnt_q == FRM_LAST) begin
                    phase_q <= ~phase_q;
                end
            end
            an_q <= an_d;
            ca_q <= ca_d;
            dp_q <= dp_d;
            fs_q <= frame_wrap;
        end
    end

    assign AN          = an_q;
    assign CA          = ca_q;
    assign DP          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb/tb_seg7_mux_driver.sv - randomized self-checking bench for seg7_mux_driver
module tb_seg7_mux_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int FRAME = DIV * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;

    logic [6:0] CA, CA_n;
    logic       DP, DP_n;
    logic [3:0] AN, AN_n;
    logic       fs, fs_n;

    seg7_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .LZ_BLANK(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .CA(CA), .DP(DP), .AN(AN), .frame_start(fs)
    );

    seg7_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .LZ_BLANK(0)) u_dut_nolz (
        .clk(clk), .rst(rst), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .CA(CA_n), .DP(DP_n), .AN(AN_n), .frame_start(fs_n)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int total = 0;
    int bad = 0;

    // Model: everything derives from c, the number of clocks since reset release.
    int          c = 0;
    logic [15:0] m_val = '0, p_val = '0;
    logic [3:0]  m_dp = '0, m_blank = '0, m_blink = '0;
    logic [3:0]  p_dp = '0, p_blank = '0, p_blink = '0;
    logic [25:0] exp_o;
    logic [25:0] obs;

    assign obs = {AN, CA, DP, fs, AN_n, CA_n, DP_n, fs_n};

    function automatic logic [11:0] model_out(input bit lzon);
        int idx, frames;
        bit phase, lzs;
        logic [3:0] nib, an;
        idx    = (c / DIV) % N;
        frames = c / FRAME;
        phase  = ((frames / BF) % 2) == 1;
        nib    = 4'((m_val >> (4 * idx)) & 16'hF);
        lzs    = lzon && (idx != 0) && ((m_val >> (4 * idx)) == 16'h0);
        an     = 4'hF;
        an[idx] = 1'b0;
        if (!en || m_blank[idx] || (m_blink[idx] && phase) || (lzs && !m_dp[idx]))
            return {4'hF, 7'h7F, 1'b1};
        if (lzs)
            return {an, 7'h7F, 1'b0};
        return {an, hex_tab[nib], ~m_dp[idx]};
    endfunction

    task automatic step();
        bit wrap;
        wrap = (c % FRAME) == FRAME - 1;
        if (rst) begin
            exp_o = {4'hF, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0};
            c = 0;
            {m_val, m_dp, m_blank, m_blink} = '0;
            {p_val, p_dp, p_blank, p_blink} = '0;
        end else begin
            exp_o = {model_out(1'b1), wrap, model_out(1'b0), wrap};
            if (wrap) begin
                if (load) {m_val, m_dp, m_blank, m_blink} = {value_in, dp_in, blank_in, blink_in};
                else      {m_val, m_dp, m_blank, m_blink} = {p_val, p_dp, p_blank, p_blink};
            end
            if (load) {p_val, p_dp, p_blank, p_blink} = {value_in, dp_in, blank_in, blink_in};
            c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic [3:0] k);
        value_in = v; dp_in = d; blank_in = b; blink_in = k; load = 1'b1;
        step();
        total++;
        if (obs !== exp_o) begin bad++; $display("FAIL load c=%0d got=%h exp=%h", c, obs, exp_o); end
        load = 1'b0;
        value_in = $urandom; dp_in = 4'($urandom);
    endtask

    task automatic test_reset();
        int zeros_n;
        rst = 1'b1; en = 1'b1;
        repeat (3) begin
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_o); end
        end
        total++;
        if ({AN, CA, DP, fs} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_state got=%b_%b_%b_%b exp=1111_1111111_1_0", AN, CA, DP, fs);
        end
        rst = 1'b0;
        step();
        total++;
        if ({AN, CA} !== {4'b1110, 7'b0000001}) begin
            bad++; $display("FAIL reset_first got=%b_%b exp=1110_0000001", AN, CA);
        end
        zeros_n = 0;
        repeat (FRAME) begin
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL first_frame c=%0d got=%h exp=%h", c, obs, exp_o); end
            if (AN_n != 4'hF && CA_n == 7'b0000001) zeros_n++;
        end
        total++;
        if (zeros_n !== FRAME) begin bad++; $display("FAIL lz_off_zero got=%0d exp=%0d", zeros_n, FRAME); end
    endtask

    task automatic test_scan();
        do_load(16'h1A3F, 4'b0010, 4'b0000, 4'b0000);
        repeat (3 * FRAME) begin
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL scan c=%0d got=%h exp=%h", c, obs, exp_o); end
        end
    endtask

    task automatic test_simultaneous();
        int guard, pulses;
        guard = 0;
        while ((c % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
            step();
            guard++;
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL align c=%0d got=%h exp=%h", c, obs, exp_o); end
        end
        total++;
        if ((c % FRAME) != FRAME - 1) begin bad++; $display("FAIL align_timeout got=%0d exp=%0d", c % FRAME, FRAME - 1); end
        do_load(16'h0042, 4'b0000, 4'b0000, 4'b0000);
        pulses = int'(fs);
        repeat (2 * FRAME) begin
            step();
            if (c <= FRAME + 1 + (c / FRAME - 1) * FRAME && c % FRAME != 0) pulses += 0;
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL simul c=%0d got=%h exp=%h", c, obs, exp_o); end
            if ((c % FRAME) != 0) pulses += int'(fs);
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL simul_fs_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_blink();
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0001);
        repeat (6 * FRAME) begin
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL blink c=%0d got=%h exp=%h", c, obs, exp_o); end
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        step();
        total++;
        if ({AN, CA} !== {4'hF, 7'h7F}) begin bad++; $display("FAIL en_off got=%b_%b exp=1111_1111111", AN, CA); end
        repeat (FRAME + 3) begin
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL en_off_run c=%0d got=%h exp=%h", c, obs, exp_o); end
        end
        en = 1'b1;
        repeat (FRAME) begin
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL en_on c=%0d got=%h exp=%h", c, obs, exp_o); end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while ((c % FRAME) != 2 && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        do_load(16'h5678, 4'b1111, 4'b0000, 4'b0000);
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        total++;
        if ({AN, CA, DP} !== {4'b1110, 7'b0000001, 1'b1}) begin
            bad++; $display("FAIL rst_mid_first got=%b_%b_%b exp=1110_0000001_1", AN, CA, DP);
        end
        repeat (2 * FRAME) begin
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL rst_mid c=%0d got=%h exp=%h", c, obs, exp_o); end
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            en       = ($urandom_range(0, 9) != 0);
            rst      = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 7) == 0);
            value_in = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            blink_in = 4'($urandom);
            step();
            total++;
            if (obs !== exp_o) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_o); end
        end
        rst = 1'b0; load = 1'b0; en = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_scan();
        test_simultaneous();
        test_blink();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
